// File: rtl/rast_pkg.sv
// Shared rasterizer types, axis indices and the MSAA step decode.
package rast_pkg;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  localparam int X_AX = 0;
  localparam int Y_AX = 1;
  localparam int Z_AX = 2;
  localparam int LL_C = 0;
  localparam int UR_C = 1;

  typedef enum logic [1:0] {
    WAIT_S = 2'd0,
    TEST_S = 2'd1
  } smpl_iter_state_t;

  // A non-one-hot code falls back to one sample per pixel.
  function automatic logic [1:0] ss_w_lg2(input logic [3:0] ss);
    logic [1:0] r;
    r = 2'd0;
    case (ss)
      4'b0001: r = 2'd3;
      4'b0010: r = 2'd2;
      4'b0100: r = 2'd1;
      4'b1000: r = 2'd0;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [SIGFIG-1:0] ss_step(input logic [3:0] ss);
    logic [SIGFIG-1:0] s;
    s = '0;
    s[RADIX - int'(ss_w_lg2(ss))] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/dff.sv
// Enabled data register with synchronous active-high clear.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/smpl_grid_step.sv
// Raster-order next-sample computation over a latched bounding box.
module smpl_grid_step
  import rast_pkg::*;
(
  input  logic [SIGFIG-1:0]           x_i,
  input  logic [SIGFIG-1:0]           y_i,
  input  logic [1:0][1:0][SIGFIG-1:0] box_i,
  input  logic [SIGFIG-1:0]           step_i,
  output logic [SIGFIG-1:0]           nx_o,
  output logic [SIGFIG-1:0]           ny_o,
  output logic                        last_samp_o
);

  // One extra bit keeps x+step from wrapping when UR sits near +max.
  logic signed [SIGFIG:0] x_s;
  logic signed [SIGFIG:0] y_s;
  logic signed [SIGFIG:0] st_s;
  logic signed [SIGFIG:0] urx_s;
  logic signed [SIGFIG:0] ury_s;
  logic signed [SIGFIG:0] nx_s;
  logic signed [SIGFIG:0] ny_s;
  logic                   end_x;
  logic                   end_y;

  always_comb begin
    x_s   = {x_i[SIGFIG-1], x_i};
    y_s   = {y_i[SIGFIG-1], y_i};
    st_s  = {1'b0, step_i};
    urx_s = {box_i[UR_C][X_AX][SIGFIG-1], box_i[UR_C][X_AX]};
    ury_s = {box_i[UR_C][Y_AX][SIGFIG-1], box_i[UR_C][Y_AX]};
    nx_s  = x_s + st_s;
    ny_s  = y_s + st_s;
    end_x = nx_s > urx_s;
    end_y = ny_s > ury_s;
    nx_o  = end_x ? box_i[LL_C][X_AX] : nx_s[SIGFIG-1:0];
    ny_o  = end_x ? ny_s[SIGFIG-1:0] : y_i;
    last_samp_o = end_x & end_y;
  end

endmodule

// File: rtl/smpl_iter_ctrl.sv
// Sample iteration controller: latches a triangle and its box,
// then emits one MSAA sample position per cycle in raster order.
module smpl_iter_ctrl
  import rast_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]        color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]          box_R13S,
  input  logic                                 validTri_R13H,
  input  logic [3:0]                           subSample_RnnnnU,
  input  logic                                 stall_R14H,
  output logic                                 halt_RnnnnL,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]        color_R14U,
  output logic [1:0][SIGFIG-1:0]               sample_R14S,
  output logic                                 validSamp_R14H
);

  smpl_iter_state_t state_q, state_d;
  logic             valid_q, valid_d;
  logic             load;
  logic             adv;

  logic [1:0][1:0][SIGFIG-1:0] box_q;
  logic [SIGFIG-1:0]           step_q;
  logic [SIGFIG-1:0]           x_q, x_d;
  logic [SIGFIG-1:0]           y_q, y_d;
  logic [SIGFIG-1:0]           nx, ny;
  logic                        last_samp;

  smpl_grid_step u_step (
    .x_i         (x_q),
    .y_i         (y_q),
    .box_i       (box_q),
    .step_i      (step_q),
    .nx_o        (nx),
    .ny_o        (ny),
    .last_samp_o (last_samp)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_q)
      WAIT_S: begin
        if (validTri_R13H) begin
          load    = 1'b1;
          valid_d = 1'b1;
          state_d = TEST_S;
        end else begin
          valid_d = 1'b0;
        end
      end
      TEST_S: begin
        if (!stall_R14H) begin
          if (last_samp) begin
            valid_d = 1'b0;
            state_d = WAIT_S;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = WAIT_S;
      end
    endcase
    x_d = load ? box_R13S[LL_C][X_AX] : nx;
    y_d = load ? box_R13S[LL_C][Y_AX] : ny;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_S;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  dff #(.W(VERTS*AXIS*SIGFIG)) u_tri (
    .clk (clk), .rst (rst), .en (load),
    .d (tri_R13S), .q (tri_R14S)
  );

  dff #(.W(COLORS*SIGFIG)) u_color (
    .clk (clk), .rst (rst), .en (load),
    .d (color_R13U), .q (color_R14U)
  );

  dff #(.W(4*SIGFIG)) u_box (
    .clk (clk), .rst (rst), .en (load),
    .d (box_R13S), .q (box_q)
  );

  dff #(.W(SIGFIG)) u_stepr (
    .clk (clk), .rst (rst), .en (load),
    .d (ss_step(subSample_RnnnnU)), .q (step_q)
  );

  dff #(.W(SIGFIG)) u_x (
    .clk (clk), .rst (rst), .en (load | adv),
    .d (x_d), .q (x_q)
  );

  dff #(.W(SIGFIG)) u_y (
    .clk (clk), .rst (rst), .en (load | adv),
    .d (y_d), .q (y_q)
  );

  assign halt_RnnnnL    = (state_q == WAIT_S);
  assign validSamp_R14H = valid_q;
  assign sample_R14S[X_AX] = x_q;
  assign sample_R14S[Y_AX] = y_q;

  a_ss_onehot : assert property (
    @(posedge clk) disable iff (rst)
    (state_q == WAIT_S && validTri_R13H) |-> $onehot(subSample_RnnnnU)
  );

endmodule

// File: tb/tb_smpl_iter_ctrl.sv
// Directed scoreboard bench for the sample iteration controller.
module tb_smpl_iter_ctrl;
  import rast_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                 rst;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_i, tri_sent;
  logic [COLORS-1:0][SIGFIG-1:0]        color_i, color_sent;
  logic [1:0][1:0][SIGFIG-1:0]          box_i;
  logic                                 valid_tri;
  logic [3:0]                           ss;
  logic                                 stall;
  logic                                 halt;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_o;
  logic [COLORS-1:0][SIGFIG-1:0]        color_o;
  logic [1:0][SIGFIG-1:0]               sample_o;
  logic                                 valid_o;

  smpl_iter_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_i),
    .color_R13U       (color_i),
    .box_R13S         (box_i),
    .validTri_R13H    (valid_tri),
    .subSample_RnnnnU (ss),
    .stall_R14H       (stall),
    .halt_RnnnnL      (halt),
    .tri_R14S         (tri_o),
    .color_R14U       (color_o),
    .sample_R14S      (sample_o),
    .validSamp_R14H   (valid_o)
  );

  typedef struct packed {
    logic [SIGFIG-1:0] x;
    logic [SIGFIG-1:0] y;
  } samp_t;

  samp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    samp_cnt = 0;
  int    n_exp;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consume one sample whenever the DUT presents one and is not stalled.
  always @(negedge clk) begin
    if (!rst && valid_o && !stall) begin
      samp_t e;
      samp_cnt++;
      chk("sample_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sample_xy", {16'd0, sample_o[Y_AX], sample_o[X_AX]},
            {16'd0, e.y, e.x});
      end
    end
  end

  task automatic send_tri(input int llx, input int lly, input int urx,
                          input int ury, input logic [3:0] ssv,
                          output int n);
    int stp;
    bit got;
    samp_t s;
    case (ssv)
      4'b0001: stp = 128;
      4'b0010: stp = 256;
      4'b0100: stp = 512;
      default: stp = 1024;
    endcase
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (halt) begin
        got = 1'b1;
        break;
      end
    end
    chk("accept_ready", 64'(got), 64'd1);
    box_i[LL_C][X_AX] = SIGFIG'(llx);
    box_i[LL_C][Y_AX] = SIGFIG'(lly);
    box_i[UR_C][X_AX] = SIGFIG'(urx);
    box_i[UR_C][Y_AX] = SIGFIG'(ury);
    for (int y = lly; y <= ury; y += stp) begin
      for (int x = llx; x <= urx; x += stp) begin
        s.x = SIGFIG'(x);
        s.y = SIGFIG'(y);
        exp_q.push_back(s);
      end
    end
    n = ((urx - llx) / stp + 1) * ((ury - lly) / stp + 1);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        tri_i[v][a] = SIGFIG'($urandom);
    for (int c = 0; c < COLORS; c++)
      color_i[c] = SIGFIG'($urandom);
    tri_sent   = tri_i;
    color_sent = color_i;
    ss        = ssv;
    valid_tri = 1'b1;
    samp_cnt  = 0;
    @(posedge clk);
    #1;
    valid_tri = 1'b0;
    // Scramble upstream inputs to show they are latched at accept.
    box_i   = {4{SIGFIG'($urandom)}};
    tri_i   = '0;
    color_i = '1;
  endtask

  task automatic wait_done(input string tag, input int n);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (halt && exp_q.size() == 0) break;
    end
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_count"}, 64'(samp_cnt), 64'(n));
    chk({tag, "_idle"}, {62'd0, halt, valid_o}, 64'd2);
  endtask

  initial begin
    rst       = 1'b1;
    stall     = 1'b0;
    valid_tri = 1'b0;
    ss        = 4'b1000;
    box_i     = '0;
    tri_i     = '0;
    color_i   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_halt", 64'(halt), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_sample", 64'(sample_o), 64'd0);
    chk("rst_tri_color", 64'(|{tri_o, color_o}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 2x2 pixel walk with exact end timing
    send_tri(0, 0, 1024, 1024, 4'b1000, n_exp);
    @(negedge clk);
    chk("t1_latency", {62'd0, valid_o, halt}, 64'd2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    chk("t1_halt_after", {62'd0, halt, valid_o}, 64'd2);
    chk("t1_count", 64'(samp_cnt), 64'(n_exp));
    chk("t1_drained", 64'(exp_q.size()), 64'd0);
    chk("t1_tri", 64'(tri_o == tri_sent), 64'd1);
    chk("t1_color", 64'(color_o == color_sent), 64'd1);

    // 8x subsampling: 81 samples
    send_tri(0, 0, 1024, 1024, 4'b0001, n_exp);
    wait_done("t2", n_exp);

    // degenerate box
    send_tri(2048, 512, 2048, 512, 4'b0100, n_exp);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("t3_halt_next", {62'd0, halt, valid_o}, 64'd2);
    chk("t3_count", 64'(samp_cnt), 64'd1);

    // stall during second sample
    send_tri(0, 0, 1024, 1024, 4'b1000, n_exp);
    @(posedge clk);
    #1;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_held", {16'd0, sample_o[Y_AX], sample_o[X_AX]},
          {16'd0, 24'd0, 24'd1024});
      chk("t4_frozen", {62'd0, halt, valid_o}, 64'd1);
      @(posedge clk);
    end
    #1;
    stall = 1'b0;
    wait_done("t4", n_exp);

    // subsample change mid-walk
    send_tri(0, 0, 1024, 1024, 4'b1000, n_exp);
    ss = 4'b0001;
    wait_done("t6", n_exp);

    // reset mid-walk, then a negative-coordinate triangle
    send_tri(0, 0, 1024, 1024, 4'b0001, n_exp);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("t5_rst_state", {62'd0, halt, valid_o}, 64'd2);
    send_tri(-2048, 3072, -1024, 4096, 4'b0010, n_exp);
    wait_done("t5b", n_exp);

    // UR at the top of the positive range must not wrap
    send_tri(8386560, -1024, 8387584, -1024, 4'b1000, n_exp);
    wait_done("wrap", n_exp);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
